// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Multiply is radix-2 shift-add and divide is restoring division. Both work on
// operand magnitudes and fix the sign after the last iteration.
// Optional build macro MULDIV_FAST_MUL_EN swaps the iterative multiply for a
// single-cycle product. Divide is identical in both builds.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; issue decode and divide special cases
// S_MUL  | shift-add iteration, one multiplier bit per cycle
// S_DIV  | restoring divide iteration, one quotient bit per cycle
// S_DONE | result/rd_out valid, done pulse, back to idle next cycle
module ex_muldiv #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // {hi, lo}: product or {remainder, quotient}
  logic [XLEN-1:0]   b_q, b_d;         // multiplicand or divisor magnitude
  logic [2:0]        f3_q, f3_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;     // product / quotient needs negation
  logic              a_neg_q, a_neg_d; // remainder needs negation
  logic [XLEN-1:0]   result_q, result_d;
  logic [4:0]        rd_out_q, rd_out_d;

  logic              a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step, mul_prod;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_shift, div_diff;
  logic [2*XLEN-1:0] div_step;
  logic [XLEN-1:0]   quo, rem, div_res;

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] f_prod;
  logic [XLEN-1:0]   fast_res;
`endif

  // Issue decode: operand signedness and magnitudes from the live EX operands.
  always_comb begin
    a_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
    b_sgn = funct3[2] ? !funct3[0] : (funct3[1:0] == 2'b01);
    a_neg = a_sgn & op_a[XLEN-1];
    b_neg = b_sgn & op_b[XLEN-1];
    abs_a = a_neg ? -op_a : op_a;
    abs_b = b_neg ? -op_b : op_b;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product; low 64 bits of the sign-extended operands are exact.
  always_comb begin
    f_prod   = {{XLEN{a_neg}}, op_a} * {{XLEN{b_neg}}, op_b};
    fast_res = (funct3[1:0] == 2'b00) ? f_prod[XLEN-1:0] : f_prod[2*XLEN-1:XLEN];
  end
`endif

  // One iteration step for each datapath plus the sign-corrected final results.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_step  = {mul_sum, acc_q[XLEN-1:1]};
    mul_prod  = neg_q ? -mul_step : mul_step;
    mul_res   = (f3_q[1:0] == 2'b00) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_q};
    div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    quo       = div_step[XLEN-1:0];
    rem       = div_step[2*XLEN-1:XLEN];
    div_res   = f3_q[1] ? (a_neg_q ? -rem : rem) : (neg_q ? -quo : quo);
  end

  // Next-state and datapath update; kill only aborts the iterating states.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    neg_d    = neg_q;
    a_neg_d  = a_neg_q;
    result_d = result_q;
    rd_out_d = rd_out_q;

    case (state_q)
      S_IDLE: begin
        if (start && !kill) begin
          f3_d    = funct3;
          rd_d    = rd_in;
          cnt_d   = '0;
          acc_d   = {{XLEN{1'b0}}, abs_a};
          b_d     = abs_b;
          neg_d   = a_neg ^ b_neg;
          a_neg_d = a_neg;
          if (funct3[2]) begin
            if (op_b == '0) begin
              state_d  = S_DONE;
              result_d = funct3[1] ? op_a : '1;
              rd_out_d = rd_in;
            end else if (!funct3[0] && op_a == MIN_NEG && op_b == '1) begin
              state_d  = S_DONE;
              result_d = funct3[1] ? '0 : MIN_NEG;
              rd_out_d = rd_in;
            end else begin
              state_d = S_DIV;
            end
          end else begin
`ifdef MULDIV_FAST_MUL_EN
            state_d  = S_DONE;
            result_d = fast_res;
            rd_out_d = rd_in;
`else
            state_d  = S_MUL;
`endif
          end
        end
      end
      S_MUL: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = S_DONE;
            result_d = mul_res;
            rd_out_d = rd_q;
          end
        end
      end
      S_DIV: begin
        if (kill) begin
          state_d = S_IDLE;
        end else begin
          acc_d = div_step;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d  = S_DONE;
            result_d = div_res;
            rd_out_d = rd_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, async active-low reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      f3_q     <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      a_neg_q  <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      neg_q    <= neg_d;
      a_neg_q  <= a_neg_d;
      result_q <= result_d;
      rd_out_q <= rd_out_d;
    end
  end

  // busy drops in DONE so ID/EX advances in the same cycle as done.
  assign busy   = (state_q == S_IDLE && start && !kill) || state_q == S_MUL || state_q == S_DIV;
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule
